lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, width of the byte address.
REQ-002 Parameter BIG_ENDIAN, default 1: 1 maps byte offset 0 to lane [31:24]; 0 maps byte offset 0 to lane [7:0].
REQ-003 Parameter TIMEOUT, default 255, maximum cycles waiting for mem_ack before a bus error; 0 disables the timeout.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  1  pipeline presents a memory operation.
REQ-007 req_ready  out  1  unit accepts a request this cycle.
REQ-008 req_op  in  3  operation code from the shared package: LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 mem_en / mem_we  out  1 / 4  memory strobe / per-lane write enables.
REQ-012 mem_addr  out  ADDR_W  word-aligned address; bits [1:0] are 0.
REQ-013 mem_wdata / mem_rdata  out / in  32 / 32  memory write / read word.
REQ-014 mem_ack  in  1  memory completion pulse; read data is valid in the same cycle.
REQ-015 rsp_valid  out  1  one-cycle completion pulse.
REQ-016 rsp_data  out  32  extended load result; 0 for stores.
REQ-017 rsp_err  out  2  00 ok, 01 load misaligned (AdEL), 10 store misaligned (AdES), 11 bus timeout.
REQ-018 rsp_badaddr  out  ADDR_W  faulting address; valid when rsp_err is nonzero.

Function
REQ-019 FSM states: IDLE, BUS, RESP; req_ready=1 only in IDLE.
REQ-020 Accept on req_valid&req_ready; latch op, addr and wdata.
REQ-021 Misalignment check at accept: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned request: IDLE->RESP, no memory strobe, rsp_err set.
REQ-022 Aligned request: IDLE->BUS.
  - In BUS, mem_en=1 every cycle; mem_we is 0 for loads.
  - Store lanes: SB one lane, SH two lanes, SW 4'b1111, lane order per BIG_ENDIAN.
REQ-023 mem_wdata: SB replicates the byte in all four lanes; SH replicates the half in both halves; SW passes through.
REQ-024 On mem_ack in BUS: capture the extracted load value, then go to RESP.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
REQ-025 A cycle counter clears on entry to BUS. When TIMEOUT!=0 and the count reaches TIMEOUT without mem_ack, go to RESP with rsp_err=11 and rsp_data=0.
REQ-026 mem_ack and timeout in the same cycle: mem_ack wins.
REQ-027 RESP lasts exactly one cycle with rsp_valid=1, then goes to IDLE.
  - Minimum aligned latency: accept cycle, one BUS cycle, RESP cycle.
REQ-028 mem_ack outside BUS is ignored.
REQ-029 Throughput is one request per three cycles minimum; no request overlap.

Reset
REQ-030 While rst=1: state=IDLE, counter=0.
  - All outputs 0 except req_ready=1.
  - Latched registers cleared.
REQ-031 Reset asserted mid-transaction aborts it immediately: no rsp_valid, mem_en drops asynchronously.

Structure
REQ-032 The shared package holds the op encodings, error codes and FSM state encodings.
REQ-033 The byte/half lane steering (select, write replication, load extraction) is a combinational sub-module, lsu_lane, parametrised by BIG_ENDIAN.

Verification
REQ-034 BIG_ENDIAN=1; SB addr 0x1001, wdata 0x000000A5, ack after 2 cycles -> mem_we=0100, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, rsp_err=00.
REQ-035 BIG_ENDIAN=1; LB addr 0x2000, mem_rdata 0x80112233 -> rsp_data=0xFFFFFF80. Same with LBU -> 0x00000080.
REQ-036 LH addr 0x2003 -> no mem_en; rsp_valid one cycle after accept, rsp_err=01, rsp_badaddr=0x2003. SW addr 0x2002 -> rsp_err=10.
REQ-037 TIMEOUT=4; LW with no ack -> rsp_err=11 after 4 BUS cycles. Ack in the 4th cycle -> rsp_err=00 with data returned.
REQ-038 BIG_ENDIAN=0; SH addr 0x12, wdata 0xBEEF -> mem_we=1100, mem_wdata=0xBEEFBEEF. Assert rst during BUS -> no rsp_valid, req_ready=1.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: op encodings, error codes,
// FSM states and the alignment helpers used at request accept.
package lsu_ctrl_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_ADEL    = 2'b01,
    ERR_ADES    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_store(op_e op);
    return op inside {SB, SH, SW};
  endfunction

  // Halfwords need an even address, words a word-aligned one; bytes never fault.
  function automatic logic is_misaligned(op_e op, logic [1:0] offset);
    case (op)
      LH, LHU, SH: return offset[0];
      LW, SW:      return offset != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic err_e misalign_err(op_e op);
    return is_store(op) ? ERR_ADES : ERR_ADEL;
  endfunction

endpackage

// File: rtl/lsu_ctrl_lane.sv
// Byte/halfword lane steering: write-enable select, store data replication
// and load extraction with sign/zero extension. Purely combinational.
module lsu_lane
  import lsu_ctrl_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  op_e         op,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  we,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_val
);

  logic [1:0]  lane;
  logic        half_hi;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane i is rdata[8i+7:8i]; big-endian puts offset 0 in the top lane.
  assign lane    = BIG_ENDIAN ? ~offset : offset;
  assign half_hi = BIG_ENDIAN ? ~offset[1] : offset[1];

  assign byte_sel = rdata[{lane, 3'b000} +: 8];
  assign half_sel = half_hi ? rdata[31:16] : rdata[15:0];

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves a value unassigned, which would otherwise infer a latch.
    we        = 4'b0000;
    wdata_rep = wdata;
    load_val  = rdata;
    case (op)
      LB:  load_val = {{24{byte_sel[7]}}, byte_sel};
      LBU: load_val = {24'b0, byte_sel};
      LH:  load_val = {{16{half_sel[15]}}, half_sel};
      LHU: load_val = {16'b0, half_sel};
      LW:  load_val = rdata;
      SB: begin
        we        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
      end
      SH: begin
        we        = half_hi ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      SW:      we = 4'b1111;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one memory op at a time, checks
// alignment, drives a single-beat memory handshake and returns a response.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] rsp_badaddr
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_e            state, state_nxt;
  op_e               req_op_e;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       data_q;
  err_e              err_q;
  logic [ADDR_W-1:0] badaddr_q;

  logic              accept;
  logic              misaligned;
  logic              timeout_hit;
  logic [3:0]        lane_we;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_load;

  assign req_op_e   = op_e'(req_op);
  assign misaligned = is_misaligned(req_op_e, req_addr[1:0]);
  // cnt holds the number of BUS cycles already completed, so this fires on
  // the TIMEOUT-th BUS cycle.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  lsu_lane #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .op        (op_q),
    .offset    (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .we        (lane_we),
    .wdata_rep (lane_wdata),
    .load_val  (lane_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    req_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid) state_nxt = misaligned ? RESP : BUS;
      end
      BUS: begin
        mem_en    = 1'b1;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_we    = lane_we;
        mem_wdata = lane_wdata;
        // An ack arriving on the timeout cycle still completes normally.
        if (mem_ack || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the latched request and response registers are reset as well, so
    // no stale address or data is visible on any output while rst is high.
    if (rst) begin
      op_q      <= LB;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      data_q    <= '0;
      err_q     <= ERR_OK;
      badaddr_q <= '0;
    end else if (accept) begin
      op_q    <= req_op_e;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      cnt     <= '0;
      data_q  <= '0;
      if (misaligned) begin
        err_q     <= misalign_err(req_op_e);
        badaddr_q <= req_addr;
      end else begin
        err_q     <= ERR_OK;
        badaddr_q <= '0;
      end
    end else if (state == BUS) begin
      if (mem_ack) begin
        if (!is_store(op_q)) data_q <= lane_load;
      end else if (timeout_hit) begin
        err_q     <= ERR_TIMEOUT;
        badaddr_q <= addr_q;
      end else if (TIMEOUT != 0) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rsp_data    = rsp_valid ? data_q : '0;
  assign rsp_err     = rsp_valid ? err_q : ERR_OK;
  assign rsp_badaddr = rsp_valid ? badaddr_q : '0;

endmodule
